cola_destinos_escritura: RTL and testbench
==========================================

# cola_destinos_escritura

- Write side of the external-destination queue: accepts 24-bit destination requests over a valid/ready handshake and stores them in a circular buffer.
- Exposes the pending entries through an 8-bit address / 24-bit destino read port, where address is an offset from the oldest entry.
- Retires entries on a pop from the consumer.
- Sits between the request sources and the destination-serving logic, and is the producer/owner of the queue contents that the consumer reads.

## Interface
- DATA_W, 24, width of one destination entry
- ADDR_W, 8, read-offset width; DEPTH = 2**ADDR_W = 256 entries

- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request present on in_destino
- in_destino  input  DATA_W  destination to enqueue; value 0 is illegal
- in_ready  output  1  queue can accept a request this cycle
- pop  input  1  consumer retires the oldest entry (offset 0)
- flush  input  1  synchronous clear of the whole queue
- address  input  ADDR_W  read offset from oldest entry
- destino  output  DATA_W  entry at head+address, combinational
- count  output  ADDR_W+1  number of stored entries, 0..DEPTH
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- err_zero  output  1  one-cycle pulse: in_destino==0 presented with in_valid
- err_underflow  output  1  one-cycle pulse: pop while empty

## Operation
- State: storage array DEPTH x DATA_W, head pointer (ADDR_W), tail pointer (ADDR_W), count (ADDR_W+1). Both pointers wrap modulo DEPTH with natural overflow.
- in_ready = ~full. It is driven from registered state only, with no combinational path from pop.
- Push fires when in_valid & in_ready & (in_destino != 0):
  - mem[tail] <= in_destino
  - tail <= tail+1
- Zero request:
  - in_valid & in_destino==0 is not stored.
  - err_zero pulses on the next cycle.
  - in_ready is unaffected, so the producer sees a handshake completion and drops the request.
- Pop fires when pop & ~empty: head <= head+1.
- pop & empty: no state change; err_underflow pulses on the next cycle.
- count update (net):
  - push only: +1
  - pop only: -1
  - both: unchanged
- Simultaneous push and pop when full: push is refused (in_ready=0), pop proceeds, count becomes DEPTH-1.
- Simultaneous push and pop when count==1 is legal. The new entry becomes offset 0 next cycle.
- flush:
  - head <= 0, tail <= 0, count <= 0.
  - Overrides any push/pop in the same cycle.
  - err pulses for that cycle are suppressed.
- Read port:
  - destino = mem[head+address] when address < count, else 0.
  - Purely combinational on address and registered state.
- Storage contents are not reset; only pointers and count are.

## Timing
- Reset (rst_n low, asynchronous):
  - head = tail = count = 0
  - empty=1, full=0, in_ready=1, destino=0
  - err_zero = err_underflow = 0
- Reset deasserted mid-operation: all queued entries are lost. The first push may occur on the first rising edge with rst_n high.
- Push latency: an entry accepted at edge N is visible on destino (address = its offset) and in count after edge N.
- Pop latency: after the pop edge, offset 0 shows the former offset 1 and count decrements.
- full/empty/in_ready change in the same cycle count changes (decoded from count register).
- err pulses are registered and high for exactly one cycle after the offending edge.
- Full-rate throughput: one push and one pop per cycle, sustained indefinitely across pointer wrap.

## Test plan
- Reset, then push 0x000001, 0x0000AB, 0xFFFFFF, 0x123456, 0x00000F on consecutive cycles -> count=5; address 0..4 read 1, 171, 16777215, 1193046, 15; address 5 reads 0.
- Pop twice -> count=3; address 0 reads 0xFFFFFF. Pop on empty queue -> err_underflow high one cycle, count stays 0.
- Push 256 entries (value = index+1) -> full=1, in_ready=0. 257th push with in_valid held: entry not stored. Then push+pop same cycle -> count=255, address 0 reads 2, and the held request is accepted one cycle later.
- Sustained simultaneous push/pop for 600 cycles with count=10 -> count stays 10, destino at address 0 tracks FIFO order across head/tail wrap.
- in_valid with in_destino=0 -> err_zero one-cycle pulse, count unchanged. flush with push+pop asserted at count=7 -> count=0, empty=1, no err pulses.
- Assert rst_n low asynchronously between edges at count=20 -> count=0, empty=1, destino=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/cola_destinos_escritura.sv
// cola_destinos_escritura: write side of the external-destination queue.
// A circular buffer of 24-bit destinations. Producers push over a valid/ready
// handshake. The consumer reads any pending entry by its offset from the
// oldest entry and retires the oldest entry with pop.
module cola_destinos_escritura #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_destino,
  output logic              in_ready,
  input  logic              pop,
  input  logic              flush,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] destino,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              err_zero,
  output logic              err_underflow
);

  localparam int DEPTH = 2 ** ADDR_W;

  // The count needs one more bit than the pointers, so that "full" (DEPTH
  // entries) and "empty" (0 entries) are distinct values.
  localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] head_q, head_d;
  logic [ADDR_W-1:0] tail_q, tail_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_zero_q, err_zero_d;
  logic              err_underflow_q, err_underflow_d;

  logic              push_fire;
  logic              pop_fire;
  logic              wr_en;
  logic [ADDR_W-1:0] rd_idx;

  // Status flags, decoded from the count register only. in_ready must not
  // depend on pop, so a push is refused when full even if a pop frees a slot.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CNT_FULL);
    in_ready = ~full;
  end

  // Handshake qualification. A zero destination completes the handshake but
  // is dropped; flush overrides any push or pop and silences the error pulses.
  always_comb begin
    push_fire       = in_valid & in_ready & (in_destino != '0) & ~flush;
    pop_fire        = pop & ~empty & ~flush;
    err_zero_d      = in_valid & (in_destino == '0) & ~flush;
    err_underflow_d = pop & empty & ~flush;
    wr_en           = push_fire;
  end

  // Next pointers and count.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_fire) begin
        tail_d = tail_q + PTR_ONE;
      end
      if (pop_fire) begin
        head_d = head_q + PTR_ONE;
      end
      if (push_fire && !pop_fire) begin
        count_d = count_q + CNT_ONE;
      end else if (pop_fire && !push_fire) begin
        count_d = count_q - CNT_ONE;
      end
    end
  end

  // Pointer, count and error-pulse registers; the queue empties on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      err_zero_q      <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      err_zero_q      <= err_zero_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  // Storage array. Contents are not reset; count gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[tail_q] <= in_destino;
    end
  end

  // Read port. The offset wraps with the head pointer, and offsets beyond the
  // stored entries read as zero, which is never a legal destination.
  always_comb begin
    rd_idx  = head_q + address;
    destino = '0;
    if ({1'b0, address} < count_q) begin
      destino = mem_q[rd_idx];
    end
  end

  // Output drives.
  always_comb begin
    count         = count_q;
    err_zero      = err_zero_q;
    err_underflow = err_underflow_q;
  end

endmodule

// File: tb/tb_cola_destinos_escritura.sv
// Directed bench for cola_destinos_escritura with hand-computed expectations.
module tb_cola_destinos_escritura;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [23:0] in_destino;
  logic        in_ready;
  logic        pop;
  logic        flush;
  logic [7:0]  address;
  logic [23:0] destino;
  logic [8:0]  count;
  logic        empty;
  logic        full;
  logic        err_zero;
  logic        err_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  cola_destinos_escritura #(.DATA_W(24), .ADDR_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_destino    (in_destino),
    .in_ready      (in_ready),
    .pop           (pop),
    .flush         (flush),
    .address       (address),
    .destino       (destino),
    .count         (count),
    .empty         (empty),
    .full          (full),
    .err_zero      (err_zero),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] a, input logic [23:0] exp, input string tag);
    address = a;
    #1;
    chk(tag, {8'h0, destino}, {8'h0, exp});
  endtask

  logic [23:0] vals [5];
  logic [23:0] q [$];
  logic [23:0] nxt;

  initial begin
    vals[0] = 24'h000001; vals[1] = 24'h0000AB; vals[2] = 24'hFFFFFF;
    vals[3] = 24'h123456; vals[4] = 24'h00000F;
    rst_n = 1'b0; in_valid = 1'b0; in_destino = '0; pop = 1'b0;
    flush = 1'b0; address = '0;

    // Reset state
    #12;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_destino", destino, 0);
    chk("rst_errz", err_zero, 0);
    chk("rst_erru", err_underflow, 0);
    rst_n = 1'b1;
    tick();

    // Five consecutive pushes
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_destino = vals[i];
      tick();
    end
    in_valid = 1'b0;
    chk("push5_count", count, 5);
    chk("push5_empty", empty, 0);
    rd(0, 24'd1, "rd0");
    rd(1, 24'd171, "rd1");
    rd(2, 24'd16777215, "rd2");
    rd(3, 24'd1193046, "rd3");
    rd(4, 24'd15, "rd4");
    rd(5, 24'd0, "rd5_beyond");

    // Two pops
    address = 0;
    pop = 1'b1;
    tick(); tick();
    pop = 1'b0;
    chk("pop2_count", count, 3);
    rd(0, 24'hFFFFFF, "pop2_head");
    rd(2, 24'h00000F, "pop2_off2");

    // Drain then pop on empty
    pop = 1'b1;
    tick(); tick(); tick();
    chk("drain_count", count, 0);
    chk("drain_erru", err_underflow, 0);
    tick();
    chk("under_pulse", err_underflow, 1);
    chk("under_count", count, 0);
    pop = 1'b0;
    tick();
    chk("under_clear", err_underflow, 0);

    // Fill to 256
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1; in_destino = 24'(i + 1);
      tick();
    end
    chk("fill_full", full, 1);
    chk("fill_ready", in_ready, 0);
    chk("fill_count", count, 256);
    in_destino = 24'h0ABCDE;
    tick();
    chk("refused_count", count, 256);
    rd(255, 24'd256, "refused_last");
    address = 0;
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("pp_full_count", count, 255);
    chk("pp_full_ready", in_ready, 1);
    rd(0, 24'd2, "pp_full_head");
    tick();
    in_valid = 1'b0;
    chk("held_count", count, 256);
    rd(255, 24'h0ABCDE, "held_value");

    // Sustained push+pop with 10 entries across pointer wrap
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_count", count, 0);
    q.delete();
    nxt = 24'd1000;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_destino = nxt; q.push_back(nxt); nxt++;
      tick();
    end
    chk("sus_start", count, 10);
    address = 0;
    for (int i = 0; i < 600; i++) begin
      in_valid = 1'b1; in_destino = nxt; pop = 1'b1;
      tick();
      void'(q.pop_front());
      q.push_back(nxt); nxt++;
      chk("sus_count", count, 10);
      chk("sus_head", destino, q[0]);
    end
    in_valid = 1'b0; pop = 1'b0;
    rd(9, q[9], "sus_tail");

    // Zero request
    in_valid = 1'b1; in_destino = 24'h0;
    tick();
    in_valid = 1'b0;
    chk("zero_pulse", err_zero, 1);
    chk("zero_count", count, 10);
    chk("zero_ready", in_ready, 1);
    tick();
    chk("zero_clear", err_zero, 0);

    // Flush overriding push+pop at count 7
    pop = 1'b1;
    tick(); tick(); tick();
    pop = 1'b0;
    chk("pre_flush_count", count, 7);
    flush = 1'b1; pop = 1'b1; in_valid = 1'b1; in_destino = 24'h000777;
    tick();
    chk("fl_count", count, 0);
    chk("fl_empty", empty, 1);
    chk("fl_errz", err_zero, 0);
    chk("fl_erru", err_underflow, 0);
    // Flush with zero request and pop on empty: no error pulses either
    in_destino = 24'h0;
    tick();
    flush = 1'b0; pop = 1'b0; in_valid = 1'b0;
    chk("fl2_errz", err_zero, 0);
    chk("fl2_erru", err_underflow, 0);
    chk("fl2_count", count, 0);

    // Asynchronous reset between edges at count 20
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_destino = 24'(24'h500 + i);
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_count", count, 20);
    address = 0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_destino", destino, 0);
    chk("arst_ready", in_ready, 1);
    #2;
    rst_n = 1'b1;
    in_valid = 1'b1; in_destino = 24'h00BEEF;
    tick();
    in_valid = 1'b0;
    chk("post_rst_count", count, 1);
    rd(0, 24'h00BEEF, "post_rst_head");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
